l1d_writeback_buffer: RTL and testbench

//   Sits between l1_data_cache lc_* port and the lower cache (LC). Queues 512b dirty-line

---
 rtl/l1d_writeback_buffer_if.sv | 42 ++++
 rtl/l1d_writeback_buffer.sv | 190 +++++++++++++++++++
 tb/tb_l1d_writeback_buffer.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1d_writeback_buffer_if.sv
// L1D <-> writeback buffer <-> lower-cache handshake bundle; slave = buffer side, master = environment.
// No logic, no latency; all flow control is valid/ready carried on these wires.
interface l1d_writeback_buffer_if #(
    parameter int PADDR_BITS = 22,
    parameter int DEPTH      = 4
);
    logic                     l1_valid_in;
    logic                     l1_ready_out;
    logic                     l1_we_in;
    logic [PADDR_BITS-1:0]    l1_addr_in;
    logic [511:0]             l1_value_in;
    logic                     l1_valid_out;
    logic                     l1_ready_in;
    logic [PADDR_BITS-1:0]    l1_addr_out;
    logic [511:0]             l1_value_out;
    logic                     lc_valid_out;
    logic                     lc_ready_in;
    logic                     lc_we_out;
    logic [PADDR_BITS-1:0]    lc_addr_out;
    logic [511:0]             lc_value_out;
    logic                     lc_valid_in;
    logic                     lc_ready_out;
    logic [PADDR_BITS-1:0]    lc_addr_in;
    logic [511:0]             lc_value_in;
    logic [$clog2(DEPTH):0]   wb_count_out;

    modport slave (
        input  l1_valid_in, l1_we_in, l1_addr_in, l1_value_in, l1_ready_in,
               lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
        output l1_ready_out, l1_valid_out, l1_addr_out, l1_value_out,
               lc_valid_out, lc_we_out, lc_addr_out, lc_value_out, lc_ready_out,
               wb_count_out
    );

    modport master (
        output l1_valid_in, l1_we_in, l1_addr_in, l1_value_in, l1_ready_in,
               lc_ready_in, lc_valid_in, lc_addr_in, lc_value_in,
        input  l1_ready_out, l1_valid_out, l1_addr_out, l1_value_out,
               lc_valid_out, lc_we_out, lc_addr_out, lc_value_out, lc_ready_out,
               wb_count_out
    );
endinterface

// File: rtl/l1d_writeback_buffer.sv
// L1D writeback queue + read-miss passthrough with RAW forwarding; WB_COALESCE_EN merges same-line writes.
// Latency: forward hit -> fill 1 cycle, miss -> LC request 1 cycle, LC fill -> L1 fill 1 cycle.
// Backpressure: L1 stalls when full or a read is outstanding; LC request held stable until accepted.
module l1d_writeback_buffer #(
    parameter int PADDR_BITS = 22,
    parameter int DEPTH      = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    l1d_writeback_buffer_if.slave bus
);
    localparam int LW = PADDR_BITS - 6;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_RESP} rd_state_e;

    logic [LW-1:0]    ent_addr_q [DEPTH];
    logic [LW-1:0]    ent_addr_d [DEPTH];
    logic [511:0]     ent_data_q [DEPTH];
    logic [511:0]     ent_data_d [DEPTH];
    logic [DEPTH-1:0] ent_vld_q, ent_vld_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic [LW-1:0]    rd_line_q, rd_line_d;
    logic [511:0]     rd_data_q, rd_data_d;
    logic             lc_lock_q, lc_lock_d;
    logic             lc_sel_rd_q, lc_sel_rd_d;

    logic [LW-1:0]    req_line;
    logic             full, sel_rd, lc_vld, head_presented, lc_fire, wb_pop;
    logic             l1_rdy, accept, wr_acc, rd_acc, push;
    logic             fwd_hit;
    logic [511:0]     fwd_data;
    logic             unused_addr_lsbs;
`ifdef WB_COALESCE_EN
    logic             coal_hit, coal;
    logic [PW-1:0]    coal_idx;
`endif

    assign req_line         = bus.l1_addr_in[PADDR_BITS-1:6];
    assign unused_addr_lsbs = ^{bus.l1_addr_in[5:0], bus.lc_addr_in[5:0]};
    assign full             = (count_q == CW'(DEPTH));

    // A locked LC request keeps its original source; otherwise a pending read beats the head writeback.
    assign sel_rd         = lc_lock_q ? lc_sel_rd_q : (rd_state_q == R_ISSUE);
    assign lc_vld         = lc_lock_q | (rd_state_q == R_ISSUE) | (count_q != '0);
    assign head_presented = lc_vld & ~sel_rd;
    assign lc_fire        = lc_vld & bus.lc_ready_in;
    assign wb_pop         = lc_fire & ~sel_rd;

    // CAM over all valid entries, oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PW-1:0] idx;
        idx      = '0;
        fwd_hit  = 1'b0;
        fwd_data = '0;
`ifdef WB_COALESCE_EN
        coal_hit = 1'b0;
        coal_idx = '0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (ent_vld_q[idx] && ent_addr_q[idx] == req_line) begin
                fwd_hit  = 1'b1;
                fwd_data = ent_data_q[idx];
`ifdef WB_COALESCE_EN
                if (!(head_presented && idx == head_q)) begin
                    coal_hit = 1'b1;
                    coal_idx = idx;
                end
`endif
            end
        end
    end

`ifdef WB_COALESCE_EN
    assign l1_rdy = (rd_state_q == R_IDLE) &&
                    (!full || (bus.l1_valid_in && bus.l1_we_in && coal_hit));
    assign coal   = wr_acc & coal_hit;
    assign push   = wr_acc & ~coal_hit;
`else
    assign l1_rdy = (rd_state_q == R_IDLE) && !full;
    assign push   = wr_acc;
`endif
    assign accept = bus.l1_valid_in & l1_rdy;
    assign wr_acc = accept & bus.l1_we_in;
    assign rd_acc = accept & ~bus.l1_we_in;

    always_comb begin
        ent_addr_d  = ent_addr_q;
        ent_data_d  = ent_data_q;
        ent_vld_d   = ent_vld_q;
        head_d      = head_q;
        tail_d      = tail_q;
        rd_state_d  = rd_state_q;
        rd_line_d   = rd_line_q;
        rd_data_d   = rd_data_q;
        lc_lock_d   = lc_vld & ~bus.lc_ready_in;
        lc_sel_rd_d = sel_rd;

        if (push) begin
            ent_addr_d[tail_q] = req_line;
            ent_data_d[tail_q] = bus.l1_value_in;
            ent_vld_d[tail_q]  = 1'b1;
            tail_d             = tail_q + PW'(1);
        end
`ifdef WB_COALESCE_EN
        if (coal) begin
            ent_data_d[coal_idx] = bus.l1_value_in;
        end
`endif
        if (wb_pop) begin
            ent_vld_d[head_q] = 1'b0;
            head_d            = head_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(wb_pop);

        case (rd_state_q)
            R_IDLE: begin
                if (rd_acc) begin
                    rd_line_d = req_line;
                    if (fwd_hit) begin
                        rd_data_d  = fwd_data;
                        rd_state_d = R_RESP;
                    end else begin
                        rd_state_d = R_ISSUE;
                    end
                end
            end
            R_ISSUE: begin
                if (lc_fire && sel_rd) rd_state_d = R_WAIT;
            end
            R_WAIT: begin
                // Fills for any other line are consumed and dropped.
                if (bus.lc_valid_in && bus.lc_addr_in[PADDR_BITS-1:6] == rd_line_q) begin
                    rd_data_d  = bus.lc_value_in;
                    rd_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (bus.l1_ready_in) rd_state_d = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            ent_vld_q   <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            rd_state_q  <= R_IDLE;
            rd_line_q   <= '0;
            rd_data_q   <= '0;
            lc_lock_q   <= 1'b0;
            lc_sel_rd_q <= 1'b0;
        end else begin
            ent_vld_q   <= ent_vld_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            rd_state_q  <= rd_state_d;
            rd_line_q   <= rd_line_d;
            rd_data_q   <= rd_data_d;
            lc_lock_q   <= lc_lock_d;
            lc_sel_rd_q <= lc_sel_rd_d;
        end
    end

    // Entry payload is qualified by ent_vld_q, so it needs no reset.
    always_ff @(posedge clk_in) begin
        ent_addr_q <= ent_addr_d;
        ent_data_q <= ent_data_d;
    end

    assign bus.l1_ready_out = l1_rdy;
    assign bus.l1_valid_out = (rd_state_q == R_RESP);
    assign bus.l1_addr_out  = (rd_state_q == R_RESP) ? {rd_line_q, 6'b0} : '0;
    assign bus.l1_value_out = (rd_state_q == R_RESP) ? rd_data_q : '0;
    assign bus.lc_valid_out = lc_vld;
    assign bus.lc_we_out    = head_presented;
    assign bus.lc_addr_out  = !lc_vld ? '0 :
                              sel_rd  ? {rd_line_q, 6'b0} : {ent_addr_q[head_q], 6'b0};
    assign bus.lc_value_out = head_presented ? ent_data_q[head_q] : '0;
    assign bus.lc_ready_out = (rd_state_q == R_WAIT);
    assign bus.wb_count_out = count_q;
endmodule

// File: tb/tb_l1d_writeback_buffer.sv
// Directed bench for l1d_writeback_buffer: stimulus queues expected LC requests and L1 fills,
// a negedge monitor compares them as they are handshaked; status outputs checked directly.
module tb_l1d_writeback_buffer;
    localparam int PB = 22;
    localparam int DP = 4;

    logic clk_in;
    logic rst_N_in;

    l1d_writeback_buffer_if #(.PADDR_BITS(PB), .DEPTH(DP)) bus ();

    l1d_writeback_buffer #(.PADDR_BITS(PB), .DEPTH(DP)) dut (
        .clk_in   (clk_in),
        .rst_N_in (rst_N_in),
        .bus      (bus.slave)
    );

    typedef struct {
        logic          we;
        logic [PB-1:0] addr;
        logic [511:0]  val;
    } lc_txn_t;

    typedef struct {
        logic [PB-1:0] addr;
        logic [511:0]  val;
    } l1_txn_t;

    lc_txn_t exp_lc[$];
    l1_txn_t exp_l1[$];
    int checks = 0;
    int errors = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic exp_lc_push(input logic we, input logic [PB-1:0] a, input logic [511:0] v);
        lc_txn_t t;
        t.we = we; t.addr = a; t.val = v;
        exp_lc.push_back(t);
    endtask

    task automatic exp_l1_push(input logic [PB-1:0] a, input logic [511:0] v);
        l1_txn_t t;
        t.addr = a; t.val = v;
        exp_l1.push_back(t);
    endtask

    task automatic l1_req(input logic we, input logic [PB-1:0] a, input logic [511:0] v);
        int n;
        bus.l1_valid_in = 1'b1;
        bus.l1_we_in    = we;
        bus.l1_addr_in  = a;
        bus.l1_value_in = v;
        n = 0;
        while (!bus.l1_ready_out && n < 50) begin
            tick();
            n++;
        end
        if (!bus.l1_ready_out) begin
            checks++;
            errors++;
            $display("FAIL l1_req_timeout: addr %0h never accepted", a);
        end
        tick();
        bus.l1_valid_in = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        bus.lc_ready_in = 1'b1;
        n = 0;
        while (bus.wb_count_out != 0 && n < 50) begin
            tick();
            n++;
        end
        chk(name, bus.wb_count_out, 0);
        bus.lc_ready_in = 1'b0;
        tick();
    endtask

    // Monitor: every handshake on either output channel must match the oldest expectation.
    always @(negedge clk_in) begin
        if (rst_N_in) begin
            if (bus.lc_valid_out && bus.lc_ready_in) begin
                if (exp_lc.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lc_unexpected: got we %0b addr %0h, none expected",
                             bus.lc_we_out, bus.lc_addr_out);
                end else begin
                    lc_txn_t t;
                    t = exp_lc.pop_front();
                    chk("lc_we", bus.lc_we_out, t.we);
                    chk("lc_addr", bus.lc_addr_out, t.addr);
                    chk("lc_value", bus.lc_value_out, t.val);
                end
            end
            if (bus.l1_valid_out && bus.l1_ready_in) begin
                if (exp_l1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL l1_unexpected: got addr %0h, none expected", bus.l1_addr_out);
                end else begin
                    l1_txn_t t;
                    t = exp_l1.pop_front();
                    chk("l1_fill_addr", bus.l1_addr_out, t.addr);
                    chk("l1_fill_value", bus.l1_value_out, t.val);
                end
            end
        end
    end

    initial begin
        int n;
        rst_N_in        = 1'b0;
        bus.l1_valid_in = 1'b0;
        bus.l1_we_in    = 1'b0;
        bus.l1_addr_in  = '0;
        bus.l1_value_in = '0;
        bus.l1_ready_in = 1'b1;
        bus.lc_ready_in = 1'b0;
        bus.lc_valid_in = 1'b0;
        bus.lc_addr_in  = '0;
        bus.lc_value_in = '0;

        // Reset state
        #3;
        chk("rst_l1_ready", bus.l1_ready_out, 1);
        chk("rst_l1_valid", bus.l1_valid_out, 0);
        chk("rst_lc_valid", bus.lc_valid_out, 0);
        chk("rst_lc_ready", bus.lc_ready_out, 0);
        chk("rst_count", bus.wb_count_out, 0);
        chk("rst_lc_addr", bus.lc_addr_out, 0);
        #10 rst_N_in = 1'b1;
        tick();

        // Single writeback held under LC backpressure, then popped
        l1_req(1'b1, 22'h4000, 512'hD0);
        exp_lc_push(1'b1, 22'h4000, 512'hD0);
        chk("wb1_count", bus.wb_count_out, 1);
        chk("wb1_lc_valid", bus.lc_valid_out, 1);
        chk("wb1_lc_we", bus.lc_we_out, 1);
        repeat (3) tick();
        chk("wb1_addr_held", bus.lc_addr_out, 22'h4000);
        chk("wb1_value_held", bus.lc_value_out, 512'hD0);
        bus.lc_ready_in = 1'b1;
        tick();
        bus.lc_ready_in = 1'b0;
        chk("wb1_count_after_pop", bus.wb_count_out, 0);

        // Fill the queue; full stalls further writes and reads
        for (int i = 0; i < DP; i++) begin
            l1_req(1'b1, 22'h2000 + 22'(i * 64), 512'(i + 1));
            exp_lc_push(1'b1, 22'h2000 + 22'(i * 64), 512'(i + 1));
        end
        chk("full_count", bus.wb_count_out, DP);
        chk("full_ready", bus.l1_ready_out, 0);
        bus.l1_valid_in = 1'b1;
        bus.l1_we_in    = 1'b1;
        bus.l1_addr_in  = 22'h3000;
        bus.l1_value_in = 512'h33;
        tick();
        tick();
        chk("full_write_stalled", bus.wb_count_out, DP);
        bus.l1_we_in   = 1'b0;
        bus.l1_addr_in = 22'h1000;
        tick();
        chk("full_read_stalled", bus.l1_ready_out, 0);
        chk("full_no_fill", bus.l1_valid_out, 0);
        bus.l1_valid_in = 1'b0;
        drain("full_drain");

        // RAW forward from a pending writeback, LC stalled on it
        l1_req(1'b1, 22'h5000, 512'hAA);
        exp_lc_push(1'b1, 22'h5000, 512'hAA);
        exp_l1_push(22'h5000, 512'hAA);
        l1_req(1'b0, 22'h5010, '0);
        chk("fwd_l1_valid", bus.l1_valid_out, 1);
        chk("fwd_lc_still_wb", bus.lc_we_out, 1);
        tick();
        chk("fwd_done", bus.l1_valid_out, 0);
        drain("fwd_drain");

        // Read miss through LC; stray fill dropped; fill held under L1 backpressure
        bus.lc_ready_in = 1'b1;
        exp_lc_push(1'b0, 22'h1000, '0);
        l1_req(1'b0, 22'h1000, '0);
        chk("miss_lc_valid", bus.lc_valid_out, 1);
        chk("miss_lc_we", bus.lc_we_out, 0);
        chk("miss_lc_addr", bus.lc_addr_out, 22'h1000);
        tick();
        bus.lc_ready_in = 1'b0;
        chk("miss_wait_ready", bus.lc_ready_out, 1);
        bus.l1_ready_in = 1'b0;
        bus.lc_valid_in = 1'b1;
        bus.lc_addr_in  = 22'h1040;
        bus.lc_value_in = 512'h5A5A;
        tick();
        chk("stray_fill_dropped", bus.l1_valid_out, 0);
        chk("stray_still_waiting", bus.lc_ready_out, 1);
        bus.lc_addr_in  = 22'h1000;
        bus.lc_value_in = 512'hDEADBEEF;
        tick();
        bus.lc_valid_in = 1'b0;
        chk("fill_l1_valid", bus.l1_valid_out, 1);
        repeat (2) tick();
        chk("fill_held_addr", bus.l1_addr_out, 22'h1000);
        chk("fill_held_value", bus.l1_value_out, 512'hDEADBEEF);
        exp_l1_push(22'h1000, 512'hDEADBEEF);
        bus.l1_ready_in = 1'b1;
        tick();
        chk("fill_done", bus.l1_valid_out, 0);

        // Pending read overtakes the next writeback once the LC lock releases
        l1_req(1'b1, 22'h6000, 512'h61);
        l1_req(1'b1, 22'h6040, 512'h62);
        l1_req(1'b0, 22'h7000, '0);
        exp_lc_push(1'b1, 22'h6000, 512'h61);
        exp_lc_push(1'b0, 22'h7000, '0);
        exp_lc_push(1'b1, 22'h6040, 512'h62);
        bus.lc_ready_in = 1'b1;
        n = 0;
        while (!(bus.wb_count_out == 0 && bus.lc_ready_out) && n < 30) begin
            tick();
            n++;
        end
        chk("order_wait_fill", bus.lc_ready_out, 1);
        bus.lc_ready_in = 1'b0;
        exp_l1_push(22'h7000, 512'h77);
        bus.lc_valid_in = 1'b1;
        bus.lc_addr_in  = 22'h7000;
        bus.lc_value_in = 512'h77;
        tick();
        bus.lc_valid_in = 1'b0;
        tick();

        // Reset mid-drain discards everything queued
        for (int i = 0; i < 3; i++) l1_req(1'b1, 22'hB000 + 22'(i * 64), 512'(16 + i));
        chk("pre_rst_count", bus.wb_count_out, 3);
        #2 rst_N_in = 1'b0;
        #1;
        chk("mid_rst_count", bus.wb_count_out, 0);
        chk("mid_rst_lc_valid", bus.lc_valid_out, 0);
        chk("mid_rst_l1_ready", bus.l1_ready_out, 1);
        tick();
        rst_N_in = 1'b1;
        tick();
        chk("post_rst_no_replay", bus.lc_valid_out, 0);
        l1_req(1'b1, 22'h9000, 512'h99);
        exp_lc_push(1'b1, 22'h9000, 512'h99);
        drain("post_rst_drain");

        // Same-line writes behind a stalled head
        l1_req(1'b1, 22'hA000, 512'h01);
        l1_req(1'b1, 22'h8000, 512'h11);
        l1_req(1'b1, 22'h8000, 512'h22);
        exp_lc_push(1'b1, 22'hA000, 512'h01);
`ifdef WB_COALESCE_EN
        chk("coal_count", bus.wb_count_out, 2);
`else
        chk("dup_count", bus.wb_count_out, 3);
        exp_lc_push(1'b1, 22'h8000, 512'h11);
`endif
        exp_lc_push(1'b1, 22'h8000, 512'h22);
        drain("dup_drain");

        n = 0;
        while ((exp_lc.size() != 0 || exp_l1.size() != 0) && n < 20) begin
            tick();
            n++;
        end
        chk("exp_lc_empty", exp_lc.size(), 0);
        chk("exp_l1_empty", exp_l1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
